// File: rtl/alu_issue_stage.sv
// Two-entry skid buffer that issues ALU operations, with writeback forwarding applied at capture.
// Latency 1 cycle. in_ready is a registered signal and deasserts only while both entries are held.
package alu_pkg;
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_control_t;
endpackage

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [4:0]   in_rs1,
    input  logic [4:0]   in_rs2,
    input  logic         in_b_is_imm,
    input  alu_control_t in_control,
    input  logic [4:0]   in_rd,
    input  logic         fwd_valid,
    input  logic [4:0]   fwd_rd,
    input  logic [N-1:0] fwd_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output alu_control_t alu_control,
    output logic [4:0]   out_rd,
    output logic [1:0]   occupancy,
    output logic [15:0]  issued_count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t       state_q, state_d;
    logic         head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    logic         in_ready_q, in_ready_d;
    logic [N-1:0] head_a_q, head_a_d, head_b_q, head_b_d;
    logic [N-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    alu_control_t head_ctl_q, head_ctl_d, skid_ctl_q, skid_ctl_d;
    logic [4:0]   head_rd_q, head_rd_d, skid_rd_q, skid_rd_d;
    logic [15:0]  cnt_q, cnt_d;

    logic         in_fire, out_fire;
    logic         fwd_hit;
    logic [N-1:0] cap_a, cap_b;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = head_vld_q & out_ready;

    // Register 0 is hardwired, so a writeback to it must never be bypassed.
    assign fwd_hit = fwd_valid && (fwd_rd != 5'd0);
    assign cap_a   = (fwd_hit && fwd_rd == in_rs1) ? fwd_result : in_a;
    assign cap_b   = (fwd_hit && !in_b_is_imm && fwd_rd == in_rs2) ? fwd_result : in_b;

    always_comb begin
        state_d    = state_q;
        head_a_d   = head_a_q;
        head_b_d   = head_b_q;
        head_ctl_d = head_ctl_q;
        head_rd_d  = head_rd_q;
        skid_a_d   = skid_a_q;
        skid_b_d   = skid_b_q;
        skid_ctl_d = skid_ctl_q;
        skid_rd_d  = skid_rd_q;
        cnt_d      = cnt_q + {15'd0, out_fire};

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d    = ONE;
                    head_a_d   = cap_a;
                    head_b_d   = cap_b;
                    head_ctl_d = in_control;
                    head_rd_d  = in_rd;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    head_a_d   = cap_a;
                    head_b_d   = cap_b;
                    head_ctl_d = in_control;
                    head_rd_d  = in_rd;
                end else if (in_fire) begin
                    state_d    = FULL;
                    skid_a_d   = cap_a;
                    skid_b_d   = cap_b;
                    skid_ctl_d = in_control;
                    skid_rd_d  = in_rd;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d    = ONE;
                    head_a_d   = skid_a_q;
                    head_b_d   = skid_b_q;
                    head_ctl_d = skid_ctl_q;
                    head_rd_d  = skid_rd_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush discards everything, including a transfer happening this same cycle.
        if (flush) begin
            state_d = EMPTY;
            cnt_d   = cnt_q;
        end

        head_vld_d = (state_d != EMPTY);
        skid_vld_d = (state_d == FULL);
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            head_a_q   <= '0;
            head_b_q   <= '0;
            head_ctl_q <= ALU_AND;
            head_rd_q  <= '0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_ctl_q <= ALU_AND;
            skid_rd_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            head_a_q   <= head_a_d;
            head_b_q   <= head_b_d;
            head_ctl_q <= head_ctl_d;
            head_rd_q  <= head_rd_d;
            skid_a_q   <= skid_a_d;
            skid_b_q   <= skid_b_d;
            skid_ctl_q <= skid_ctl_d;
            skid_rd_q  <= skid_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = head_vld_q;
    assign alu_a        = head_a_q;
    assign alu_b        = head_b_q;
    assign alu_control  = head_ctl_q;
    assign out_rd       = head_rd_q;
    assign occupancy    = {skid_vld_q, head_vld_q & ~skid_vld_q};
    assign issued_count = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: streaming, backpressure, forwarding, flush, async reset, count wrap.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_a, in_b;
    logic [4:0]   in_rs1, in_rs2;
    logic         in_b_is_imm;
    alu_control_t in_control;
    logic [4:0]   in_rd;
    logic         fwd_valid;
    logic [4:0]   fwd_rd;
    logic [31:0]  fwd_result;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  alu_a, alu_b;
    alu_control_t alu_control;
    logic [4:0]   out_rd;
    logic [1:0]   occupancy;
    logic [15:0]  issued_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.N(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_b_is_imm(in_b_is_imm), .in_control(in_control), .in_rd(in_rd),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .out_rd(out_rd),
        .occupancy(occupancy), .issued_count(issued_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_rd    = rd;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_rs1 = '0; in_rs2 = '0; in_b_is_imm = 1'b0; in_control = ALU_ADD; in_rd = '0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_result = '0; out_ready = 1'b0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_occ", {30'd0, occupancy}, 32'd0);
        chk("rst_cnt", {16'd0, issued_count}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_ctl", {28'd0, alu_control}, {28'd0, ALU_AND});
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Streaming: one op per cycle, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(i, 32'd10, 5'(i));
            tick();
            chk("stream_vld", {31'd0, out_valid}, 32'd1);
            chk("stream_a", alu_a, i);
            chk("stream_b", alu_b, 32'd10);
            chk("stream_rd", {27'd0, out_rd}, i);
        end
        chk("stream_ctl", {28'd0, alu_control}, {28'd0, ALU_ADD});
        in_valid = 1'b0;
        tick();
        chk("stream_drain_vld", {31'd0, out_valid}, 32'd0);
        chk("stream_cnt", {16'd0, issued_count}, 32'd4);

        // Backpressure: A, B accepted, C stalls, then all emerge in order.
        out_ready = 1'b0;
        offer(32'hA, 32'd0, 5'd1);
        tick();
        chk("bp_occ1", {30'd0, occupancy}, 32'd1);
        offer(32'hB, 32'd0, 5'd2);
        tick();
        chk("bp_occ2", {30'd0, occupancy}, 32'd2);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        offer(32'hC, 32'd0, 5'd3);
        tick();
        chk("bp_hold_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_hold_a", alu_a, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_out_b", alu_a, 32'hB);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_out_c", alu_a, 32'hC);
        chk("bp_occ_c", {30'd0, occupancy}, 32'd1);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", {30'd0, occupancy}, 32'd0);
        chk("bp_cnt", {16'd0, issued_count}, 32'd7);

        // Forwarding: rs1 hit with immediate b, then rd=0 (no hit), then rs2 hit.
        out_ready = 1'b0;
        in_rs1 = 5'd5; in_rs2 = 5'd5; in_b_is_imm = 1'b1;
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_result = 32'hDEAD_BEEF;
        offer(32'h11, 32'h22, 5'd7);
        tick();
        chk("fwd_a_hit", alu_a, 32'hDEAD_BEEF);
        chk("fwd_b_imm", alu_b, 32'h22);
        out_ready = 1'b1;
        fwd_rd = 5'd0;
        tick();
        chk("fwd_rd0_a", alu_a, 32'h11);
        chk("fwd_rd0_b", alu_b, 32'h22);
        in_rs1 = 5'd3; in_b_is_imm = 1'b0; fwd_rd = 5'd5;
        offer(32'h33, 32'h44, 5'd8);
        tick();
        chk("fwd_b_hit", alu_b, 32'hDEAD_BEEF);
        chk("fwd_a_miss", alu_a, 32'h33);
        in_valid = 1'b0; fwd_valid = 1'b0;
        tick();
        chk("fwd_cnt", {16'd0, issued_count}, 32'd10);

        // Flush while full with simultaneous input and output.
        out_ready = 1'b0;
        offer(32'h1, 32'd0, 5'd1);
        tick();
        offer(32'h2, 32'd0, 5'd2);
        tick();
        chk("fl_pre_occ", {30'd0, occupancy}, 32'd2);
        out_ready = 1'b1; flush = 1'b1;
        offer(32'h3, 32'd0, 5'd3);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ", {30'd0, occupancy}, 32'd0);
        chk("fl_vld", {31'd0, out_valid}, 32'd0);
        chk("fl_rdy", {31'd0, in_ready}, 32'd1);
        chk("fl_cnt", {16'd0, issued_count}, 32'd10);

        // Async reset between edges while full.
        out_ready = 1'b0;
        offer(32'h5, 32'd0, 5'd1);
        tick();
        offer(32'h6, 32'd0, 5'd2);
        tick();
        in_valid = 1'b0;
        chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_vld", {31'd0, out_valid}, 32'd0);
        chk("ar_occ", {30'd0, occupancy}, 32'd0);
        chk("ar_cnt", {16'd0, issued_count}, 32'd0);
        chk("ar_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        offer(32'h77, 32'd0, 5'd4);
        tick();
        chk("ar_first_in", alu_a, 32'h77);
        chk("ar_first_vld", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        // Count wrap: reset, then 65535 transfers, then one more.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        offer(32'h0, 32'd0, 5'd1);
        repeat (65535) tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_ffff", {16'd0, issued_count}, 32'h0000_FFFF);
        offer(32'h9, 32'd0, 5'd1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("wrap_zero", {16'd0, issued_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
